mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Registers the execute-stage outputs and resolves the branch (PCSrc) for the fetch stage.
- Performs data-memory loads and stores over a req/ack handshake, with byte/halfword lane steering and load extension.
- Stalls the upstream pipeline while an access is outstanding, and presents a registered result bundle to writeback.

Parameters:
TIMEOUT, 64, maximum cycles to wait for dmem_ack before aborting the access with mem_err.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
MemWr  in  1  store request from execute
MemtoReg  in  1  load request / writeback source select
RegWr  in  1  register write enable
Branch  in  1  branch instruction
Zero  in  1  ALU zero flag
Jump  in  1  jump (pass-through)
Jal  in  1  jump-and-link (pass-through)
Loadext  in  1  1=sign-extend loads, 0=zero-extend
Dsize  in  2  00 word, 01 halfword, 10 byte, 11 treated as word
FPoint  in  2  pass-through
ALUout  in  32  effective address / ALU result
BusB  in  32  store data
BranchTarget  in  32  branch target address
Delayslot2  in  32  link address
Rw  in  5  destination register
dmem_req  out  1  memory request
dmem_we  out  1  1=write
dmem_addr  out  32  word address; ALUout with bits [1:0] cleared
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables; be[3] is addr byte 0 (big-endian)
dmem_rdata  in  32  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete
stall  out  1  hold upstream stages
PCSrc  out  1  Branch & Zero of the registered instruction
BranchTargetOut  out  32  registered BranchTarget
wbRegWr, wbMemtoReg, wbJal  out  1 each  writeback controls
wbFPoint  out  2  writeback pass-through
wbRw  out  5  writeback destination
wbALUout, wbMemData, wbDelayslot2  out  32 each  writeback data
mem_err  out  1  sticky; set on misalignment or timeout

Behaviour:
- Input register: captures all execute outputs on posedge clk when stall=0; holds when stall=1.
- PCSrc and BranchTargetOut are driven from the input register, so they are valid one cycle after capture.
- Reset: every register and output is 0, FSM goes to IDLE, mem_err=0. Reset mid-access drops dmem_req the next cycle; a late dmem_ack after that is ignored.
- Alignment:
  - halfword requires addr[0]=0; word requires addr[1:0]=0.
  - A misaligned op issues no request, sets mem_err, and completes as a bubble with wbRegWr=0.
- FSM states:
  - IDLE: if the registered op is a load or store and is aligned, go to ACCESS; otherwise the WB register captures the op at the next edge (1-cycle latency).
  - ACCESS: dmem_req=1, with addr/we/be/wdata stable. When dmem_ack=1, the WB register captures the op at that edge; then go to DONE if the next captured op is a memory op, else IDLE. If no ack after TIMEOUT cycles, set mem_err, capture a bubble and go to IDLE.
  - DONE: behaves as IDLE; exists only so a back-to-back memory op drops dmem_req for at least one cycle.
- stall = registered op is an aligned memory op, not yet completed, and dmem_ack=0. stall is combinational from state and dmem_ack. While stall=1 the WB register takes a bubble each cycle (wbRegWr=0, all other WB outputs hold).
- Store lanes:
  - byte: wdata = {4{BusB[7:0]}}, be = 1000 >> addr[1:0].
  - halfword: wdata = {2{BusB[15:0]}}, be = 1100 when addr[1]=0, else 0011.
  - word: be = 1111.
- Load extract:
  - byte: rdata[31-8*addr[1:0] -: 8].
  - halfword: rdata[31-16*addr[1] -: 16].
  - Result is sign- or zero-extended per Loadext and captured into wbMemData.
- Stores capture wbRegWr as given (normally 0).
- Non-memory ops leave wbMemData unchanged.
- Simultaneous ack and a new op: the WB capture and the input-register capture occur on the same edge.

Test Plan:
- ALU op, RegWr=1, ALUout=0x1234: wbALUout=0x1234 and wbRegWr=1 two edges after input; no dmem_req.
- Byte load at 0x103, Loadext=1, rdata=0x000000F0, ack after 3 cycles: stall high for 3 cycles; wbMemData=0xFFFFFFF0; with Loadext=0, wbMemData=0x000000F0.
- Halfword store at 0x102, BusB=0xABCD: dmem_addr=0x100, be=0011, wdata=0xABCDABCD, we=1.
- Halfword load at 0x101: no dmem_req, mem_err=1, wbRegWr=0, stall=0.
- Two back-to-back word loads with immediate ack: dmem_req low for one cycle between the accesses; both results delivered in order.
- No ack for 64 cycles: mem_err=1, stall releases; assert reset mid-ACCESS: dmem_req=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    modport master (output req, we, addr, wdata, be, input rdata, ack);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; registers execute outputs, resolves PCSrc, runs dmem
// req/ack accesses with big-endian lane steering and presents a registered writeback bundle.
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWr,
    input  logic        MemtoReg,
    input  logic        RegWr,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        Jal,
    input  logic        Loadext,
    input  logic [1:0]  Dsize,
    input  logic [1:0]  FPoint,
    input  logic [31:0] ALUout,
    input  logic [31:0] BusB,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Delayslot2,
    input  logic [4:0]  Rw,
    mem_stage_if.master dmem,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] BranchTargetOut,
    output logic        wbRegWr,
    output logic        wbMemtoReg,
    output logic        wbJal,
    output logic [1:0]  wbFPoint,
    output logic [4:0]  wbRw,
    output logic [31:0] wbALUout,
    output logic [31:0] wbMemData,
    output logic [31:0] wbDelayslot2,
    output logic        mem_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic memwr_q, memtoreg_q, regwr_q, branch_q, zero_q, jal_q, loadext_q;
    logic [1:0] dsize_q, fpoint_q;
    logic [31:0] aluout_q, busb_q, target_q, dslot_q;
    logic [4:0] rw_q;
    logic is_mem, is_byte, is_half, is_word, misal, go, load, ack, tmo, cap;
    logic [3:0] be;
    logic [31:0] wdata, ld;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    logic unused_jump;
    assign unused_jump = Jump;
    assign is_mem  = memwr_q || memtoreg_q;
    assign is_byte = dsize_q == 2'b10;
    assign is_half = dsize_q == 2'b01;
    assign is_word = !is_byte && !is_half;
    assign misal   = (is_half && aluout_q[0]) || (is_word && aluout_q[1:0] != 2'b00);
    assign go      = is_mem && !misal;
    assign load    = memtoreg_q && !memwr_q;
    assign ack     = state_q == ACCESS && dmem.ack;
    assign tmo     = state_q == ACCESS && !dmem.ack && cnt_q == CW'(TIMEOUT - 1);
    // A timed-out access counts as completed so the stalled op is released.
    assign stall   = state_q == ACCESS ? !dmem.ack && !tmo : go;
    assign cap     = state_q == ACCESS ? ack : !is_mem;
    assign PCSrc   = branch_q && zero_q;
    assign BranchTargetOut = target_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (state_q == ACCESS) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ack ? ((MemWr || MemtoReg) ? DONE : IDLE) : tmo ? IDLE : ACCESS;
        end else begin
            state_d = go ? ACCESS : IDLE;
        end
    end
    // Lane 0 is the most significant byte (big-endian).
    always_comb begin
        be    = is_byte ? 4'b1000 >> aluout_q[1:0] : is_half ? (aluout_q[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        wdata = is_byte ? {4{busb_q[7:0]}} : is_half ? {2{busb_q[15:0]}} : busb_q;
        rbyte = dmem.rdata[{~aluout_q[1:0], 3'b000} +: 8];
        rhalf = dmem.rdata[{~aluout_q[1], 4'b0000} +: 16];
        ld    = is_byte ? {{24{loadext_q && rbyte[7]}}, rbyte}
              : is_half ? {{16{loadext_q && rhalf[15]}}, rhalf} : dmem.rdata;
    end
    assign dmem.req   = state_q == ACCESS;
    assign dmem.we    = dmem.req && memwr_q;
    assign dmem.addr  = dmem.req ? {aluout_q[31:2], 2'b00} : '0;
    assign dmem.be    = dmem.req ? be : '0;
    assign dmem.wdata = dmem.req ? wdata : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            {memwr_q, memtoreg_q, regwr_q, branch_q, zero_q, jal_q, loadext_q, dsize_q, fpoint_q,
             aluout_q, busb_q, target_q, dslot_q, rw_q} <= '0;
            {wbRegWr, wbMemtoReg, wbJal, wbFPoint, wbRw, wbALUout, wbMemData, wbDelayslot2} <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!stall)
                {memwr_q, memtoreg_q, regwr_q, branch_q, zero_q, jal_q, loadext_q, dsize_q, fpoint_q,
                 aluout_q, busb_q, target_q, dslot_q, rw_q} <= {MemWr, MemtoReg, RegWr, Branch, Zero,
                 Jal, Loadext, Dsize, FPoint, ALUout, BusB, BranchTarget, Delayslot2, Rw};
            if ((is_mem && misal) || tmo)
                mem_err <= 1'b1;
            wbRegWr <= 1'b0;
            if (cap) begin
                wbRegWr      <= regwr_q;
                wbMemtoReg   <= memtoreg_q;
                wbJal        <= jal_q;
                wbFPoint     <= fpoint_q;
                wbRw         <= rw_q;
                wbALUout     <= aluout_q;
                wbDelayslot2 <= dslot_q;
                if (load)
                    wbMemData <= ld;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with a hand-driven dmem responder.
module tb_mem_stage;
    logic clk, reset;
    logic MemWr, MemtoReg, RegWr, Branch, Zero, Jump, Jal, Loadext;
    logic [1:0] Dsize, FPoint;
    logic [31:0] ALUout, BusB, BranchTarget, Delayslot2;
    logic [4:0] Rw;
    logic stall, PCSrc, wbRegWr, wbMemtoReg, wbJal, mem_err;
    logic [31:0] BranchTargetOut, wbALUout, wbMemData, wbDelayslot2;
    logic [1:0] wbFPoint;
    logic [4:0] wbRw;
    int n_cmp = 0;
    int n_bad = 0;
    mem_stage_if bus();
    mem_stage #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .MemWr(MemWr), .MemtoReg(MemtoReg), .RegWr(RegWr),
        .Branch(Branch), .Zero(Zero), .Jump(Jump), .Jal(Jal), .Loadext(Loadext), .Dsize(Dsize),
        .FPoint(FPoint), .ALUout(ALUout), .BusB(BusB), .BranchTarget(BranchTarget),
        .Delayslot2(Delayslot2), .Rw(Rw), .dmem(bus), .stall(stall), .PCSrc(PCSrc),
        .BranchTargetOut(BranchTargetOut), .wbRegWr(wbRegWr), .wbMemtoReg(wbMemtoReg),
        .wbJal(wbJal), .wbFPoint(wbFPoint), .wbRw(wbRw), .wbALUout(wbALUout),
        .wbMemData(wbMemData), .wbDelayslot2(wbDelayslot2), .mem_err(mem_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_ex;
        {MemWr, MemtoReg, RegWr, Branch, Zero, Jump, Jal, Loadext} = '0;
        {Dsize, FPoint, ALUout, BusB, BranchTarget, Delayslot2, Rw} = '0;
    endtask
    task automatic drive(input logic wr, input logic rd, input logic rwe, input logic [1:0] sz,
                         input logic ext, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        clear_ex();
        MemWr = wr; MemtoReg = rd; RegWr = rwe; Dsize = sz; Loadext = ext; ALUout = a; BusB = b; Rw = r;
    endtask
    task automatic do_reset;
        reset = 1'b1; clear_ex(); bus.ack = 1'b0; bus.rdata = '0;
        tick(); tick();
        reset = 1'b0;
    endtask
    task automatic test_reset;
        reset = 1'b1; bus.ack = 1'b0; bus.rdata = '0;
        clear_ex();
        RegWr = 1'b1; Branch = 1'b1; Zero = 1'b1; ALUout = 32'h55; BranchTarget = 32'h80;
        tick(); tick();
        @(negedge clk);
        n_cmp++; if ({PCSrc, BranchTargetOut} !== 33'h0) begin n_bad++; $display("FAIL reset_branch: got %b/%h want 0/0", PCSrc, BranchTargetOut); end
        n_cmp++; if ({wbRegWr, wbALUout, wbRw} !== 38'h0) begin n_bad++; $display("FAIL reset_wb: got %b/%h/%0d want 0", wbRegWr, wbALUout, wbRw); end
        n_cmp++; if ({bus.req, bus.we, bus.be, bus.addr, stall, mem_err} !== 40'h0) begin n_bad++; $display("FAIL reset_bus: req=%b be=%b addr=%h stall=%b err=%b want 0", bus.req, bus.be, bus.addr, stall, mem_err); end
        reset = 1'b0; clear_ex();
        tick();
    endtask
    task automatic test_alu;
        drive(0, 0, 1, 2'b00, 0, 32'h1234, 32'h0, 5'd4);
        Branch = 1'b1; Zero = 1'b1; BranchTarget = 32'h400; Jal = 1'b1; Delayslot2 = 32'h808;
        tick(); clear_ex();
        @(negedge clk);
        n_cmp++; if ({PCSrc, BranchTargetOut} !== {1'b1, 32'h400}) begin n_bad++; $display("FAIL alu_pcsrc: got %b/%h want 1/00000400", PCSrc, BranchTargetOut); end
        n_cmp++; if ({bus.req, stall, wbRegWr} !== 3'b000) begin n_bad++; $display("FAIL alu_early: req=%b stall=%b wbRegWr=%b want 000", bus.req, stall, wbRegWr); end
        tick();
        n_cmp++; if ({wbRegWr, wbALUout, wbRw, wbJal, wbDelayslot2} !== {1'b1, 32'h1234, 5'd4, 1'b1, 32'h808}) begin n_bad++; $display("FAIL alu_wb: got %b/%h/%0d/%b/%h want 1/00001234/4/1/00000808", wbRegWr, wbALUout, wbRw, wbJal, wbDelayslot2); end
        n_cmp++; if ({bus.req, PCSrc} !== 2'b00) begin n_bad++; $display("FAIL alu_after: req=%b pcsrc=%b want 00", bus.req, PCSrc); end
    endtask
    task automatic test_load(input logic [1:0] sz, input logic [31:0] a, input logic ext,
                             input logic [31:0] rd, input logic [3:0] exp_be, input logic [31:0] exp_d);
        int st, acc;
        bit done;
        st = 0; acc = 0; done = 1'b0;
        drive(0, 1, 1, sz, ext, a, 32'h0, 5'd5);
        tick(); clear_ex();
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.req) begin
                acc++;
                if (acc == 1) begin
                    n_cmp++; if ({bus.we, bus.be, bus.addr} !== {1'b0, exp_be, a & 32'hFFFF_FFFC}) begin n_bad++; $display("FAIL load_bus %h: we=%b be=%b addr=%h want 0/%b/%h", a, bus.we, bus.be, bus.addr, exp_be, a & 32'hFFFF_FFFC); end
                end
                if (acc == 3) begin bus.ack = 1'b1; bus.rdata = rd; end
            end
            #1;
            if (stall) st++;
            done = bus.ack;
            tick();
            bus.ack = 1'b0; bus.rdata = '0;
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL load_ack %h: access never acknowledged, req cycles=%0d want 3", a, acc); end
        n_cmp++; if (st != 3) begin n_bad++; $display("FAIL load_stall %h: stall cycles=%0d want 3", a, st); end
        n_cmp++; if ({wbMemData, wbRegWr, wbMemtoReg, wbRw} !== {exp_d, 1'b1, 1'b1, 5'd5}) begin n_bad++; $display("FAIL load_wb %h: data=%h regwr=%b m2r=%b rw=%0d want %h/1/1/5", a, wbMemData, wbRegWr, wbMemtoReg, wbRw, exp_d); end
    endtask
    task automatic test_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] exp_be, input logic [31:0] exp_w, input logic [31:0] prev_d);
        bit done;
        done = 1'b0;
        drive(1, 0, 0, sz, 0, a, b, 5'd7);
        tick(); clear_ex();
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (bus.req) begin
                n_cmp++; if ({bus.we, bus.be, bus.addr, bus.wdata} !== {1'b1, exp_be, a & 32'hFFFF_FFFC, exp_w}) begin n_bad++; $display("FAIL store_bus %h: we=%b be=%b addr=%h wdata=%h want 1/%b/%h/%h", a, bus.we, bus.be, bus.addr, bus.wdata, exp_be, a & 32'hFFFF_FFFC, exp_w); end
                bus.ack = 1'b1; done = 1'b1;
            end
            tick();
            bus.ack = 1'b0;
        end
        n_cmp++; if ({done, wbRegWr, wbMemData} !== {1'b1, 1'b0, prev_d}) begin n_bad++; $display("FAIL store_wb %h: done=%b regwr=%b memdata=%h want 1/0/%h", a, done, wbRegWr, wbMemData, prev_d); end
    endtask
    task automatic test_misaligned;
        do_reset();
        drive(0, 1, 1, 2'b01, 1, 32'h101, 32'h0, 5'd9);
        tick(); clear_ex();
        @(negedge clk);
        n_cmp++; if ({bus.req, stall, mem_err} !== 3'b000) begin n_bad++; $display("FAIL misal_pre: req=%b stall=%b err=%b want 000", bus.req, stall, mem_err); end
        tick();
        n_cmp++; if ({mem_err, wbRegWr, bus.req, stall} !== 4'b1000) begin n_bad++; $display("FAIL misal_post: err=%b regwr=%b req=%b stall=%b want 1000", mem_err, wbRegWr, bus.req, stall); end
    endtask
    task automatic test_back_to_back;
        drive(0, 1, 1, 2'b00, 0, 32'h200, 32'h0, 5'd1);
        tick();
        drive(0, 1, 1, 2'b00, 0, 32'h204, 32'h0, 5'd2);
        @(negedge clk);
        n_cmp++; if ({bus.req, stall} !== 2'b01) begin n_bad++; $display("FAIL b2b_c1: req=%b stall=%b want 01", bus.req, stall); end
        tick();
        @(negedge clk);
        n_cmp++; if ({bus.req, bus.addr} !== {1'b1, 32'h200}) begin n_bad++; $display("FAIL b2b_a1: req=%b addr=%h want 1/00000200", bus.req, bus.addr); end
        bus.ack = 1'b1; bus.rdata = 32'h1111_2222;
        tick();
        bus.ack = 1'b0; bus.rdata = '0; clear_ex();
        n_cmp++; if ({wbMemData, wbRw, wbRegWr} !== {32'h1111_2222, 5'd1, 1'b1}) begin n_bad++; $display("FAIL b2b_wb1: data=%h rw=%0d regwr=%b want 11112222/1/1", wbMemData, wbRw, wbRegWr); end
        @(negedge clk);
        n_cmp++; if ({bus.req, stall} !== 2'b01) begin n_bad++; $display("FAIL b2b_gap: req=%b stall=%b want 01", bus.req, stall); end
        tick();
        @(negedge clk);
        n_cmp++; if ({bus.req, bus.addr} !== {1'b1, 32'h204}) begin n_bad++; $display("FAIL b2b_a2: req=%b addr=%h want 1/00000204", bus.req, bus.addr); end
        bus.ack = 1'b1; bus.rdata = 32'h3333_4444;
        tick();
        bus.ack = 1'b0; bus.rdata = '0;
        n_cmp++; if ({wbMemData, wbRw, wbRegWr, bus.req} !== {32'h3333_4444, 5'd2, 1'b1, 1'b0}) begin n_bad++; $display("FAIL b2b_wb2: data=%h rw=%0d regwr=%b req=%b want 33334444/2/1/0", wbMemData, wbRw, wbRegWr, bus.req); end
    endtask
    task automatic test_timeout;
        int nreq;
        nreq = 0;
        do_reset();
        drive(0, 1, 1, 2'b00, 0, 32'h300, 32'h0, 5'd3);
        tick(); clear_ex();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.req) nreq++;
            if (!stall) break;
        end
        n_cmp++; if ({stall, mem_err} !== 2'b00 || nreq != 64) begin n_bad++; $display("FAIL timeout_release: stall=%b err=%b req cycles=%0d want 0/0/64", stall, mem_err, nreq); end
        tick();
        n_cmp++; if ({mem_err, bus.req, stall, wbRegWr} !== 4'b1000) begin n_bad++; $display("FAIL timeout_err: err=%b req=%b stall=%b regwr=%b want 1000", mem_err, bus.req, stall, wbRegWr); end
    endtask
    task automatic test_reset_mid_access;
        drive(0, 1, 1, 2'b00, 0, 32'h400, 32'h0, 5'd6);
        BranchTarget = 32'h4444;
        tick(); clear_ex();
        tick(); tick();
        @(negedge clk);
        n_cmp++; if ({bus.req, BranchTargetOut, mem_err} !== {1'b1, 32'h4444, 1'b1}) begin n_bad++; $display("FAIL mid_pre: req=%b bt=%h err=%b want 1/00004444/1", bus.req, BranchTargetOut, mem_err); end
        reset = 1'b1;
        tick();
        n_cmp++; if ({bus.req, bus.addr, stall, mem_err, BranchTargetOut, wbRegWr, wbMemData} !== 100'h0) begin n_bad++; $display("FAIL mid_reset: req=%b addr=%h stall=%b err=%b bt=%h regwr=%b data=%h want 0", bus.req, bus.addr, stall, mem_err, BranchTargetOut, wbRegWr, wbMemData); end
        reset = 1'b0; bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
        tick();
        bus.ack = 1'b0; bus.rdata = '0;
        n_cmp++; if ({bus.req, wbRegWr, wbMemData, mem_err} !== 35'h0) begin n_bad++; $display("FAIL late_ack: req=%b regwr=%b data=%h err=%b want 0", bus.req, wbRegWr, wbMemData, mem_err); end
    endtask
    initial begin
        test_reset();
        test_alu();
        test_load(2'b10, 32'h103, 1'b1, 32'h0000_00F0, 4'b0001, 32'hFFFF_FFF0);
        test_load(2'b10, 32'h103, 1'b0, 32'h0000_00F0, 4'b0001, 32'h0000_00F0);
        test_load(2'b01, 32'h102, 1'b1, 32'h1234_8765, 4'b0011, 32'hFFFF_8765);
        test_load(2'b01, 32'h100, 1'b0, 32'h8765_1234, 4'b1100, 32'h0000_8765);
        test_load(2'b00, 32'h104, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        test_store(2'b10, 32'h101, 32'h1234_5655, 4'b0100, 32'h5555_5555, 32'hDEAD_BEEF);
        test_store(2'b01, 32'h102, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD, 32'hDEAD_BEEF);
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
